// File: rtl/adder_pkg.sv
// adder_pkg: width constants shared by the 32-bit carry-lookahead adder
package adder_pkg;
  localparam int ADD_W = 32;
  localparam int GRP_W = 4;
  localparam int N_GRP = ADD_W / GRP_W;
endpackage

// File: rtl/adder_32_cla4.sv
// cla4: 4-bit carry-lookahead group producing sum bits and group generate/propagate
module cla4
  import adder_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             ci,
  output logic [GRP_W-1:0] s,
  output logic             gg,
  output logic             pg
);
  logic [GRP_W-1:0] g, p, c;
  assign g = a & b;
  assign p = a ^ b;
  // carries into each bit, all flattened from ci so no ripple inside the group
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign s = p ^ c;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg = &p;
endmodule

// File: rtl/adder_32.sv
// adder_32: registered 32-bit two-level carry-lookahead adder with carry out
// ADDER32_OVF_EN adds the registered signed-overflow output OF
module adder_32
  import adder_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [32:1]   A,
  input  logic [32:1]   B,
  input  logic          cin,
  output logic [32:1]   S,
  output logic          C32
`ifdef ADDER32_OVF_EN
  ,output logic         OF
`endif
);
  logic [N_GRP-1:0] gg, pg;
  logic [N_GRP:0]   cg;
  logic [32:1]      sum_d, s_q;
  logic             c32_q;
  // carry into group j+1 as a flat sum of products over groups 0..j and cin
  function automatic logic lac(input logic [N_GRP-1:0] g, input logic [N_GRP-1:0] p,
                               input logic ci, input int j);
    logic acc, prod;
    prod = ci;
    for (int m = 0; m <= j; m++) prod = prod & p[m];
    acc = prod;
    for (int k = 0; k <= j; k++) begin
      prod = g[k];
      for (int m = k + 1; m <= j; m++) prod = prod & p[m];
      acc = acc | prod;
    end
    return acc;
  endfunction
  assign cg[0] = cin;
  for (genvar i = 0; i < N_GRP; i++) begin : g_grp
    cla4 u_cla4 (
      .a  (A[GRP_W*i+1 +: GRP_W]),
      .b  (B[GRP_W*i+1 +: GRP_W]),
      .ci (cg[i]),
      .s  (sum_d[GRP_W*i+1 +: GRP_W]),
      .gg (gg[i]),
      .pg (pg[i])
    );
    assign cg[i+1] = lac(gg, pg, cin, i);
  end
  always_ff @(posedge clk) begin
    s_q   <= rst ? '0 : sum_d;
    c32_q <= rst ? 1'b0 : cg[N_GRP];
  end
  assign S   = s_q;
  assign C32 = c32_q;
`ifdef ADDER32_OVF_EN
  logic of_q;
  always_ff @(posedge clk)
    of_q <= rst ? 1'b0 : (A[32] == B[32]) && (sum_d[32] != A[32]);
  assign OF = of_q;
`endif
endmodule

// File: tb/tb_adder_32.sv
// tb_adder_32: directed and randomized self-checking bench for adder_32
module tb_adder_32;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        cin;
  logic [31:0] s;
  logic        c32;
  int          n_vec = 0;
  int          n_bad = 0;
`ifdef ADDER32_OVF_EN
  logic        of;
`endif
  always #5 clk = ~clk;
  adder_32 dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .cin (cin),
    .S   (s),
    .C32 (c32)
`ifdef ADDER32_OVF_EN
    ,.OF (of)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  // drive one operand set, clock it in, then check just after the edge
  task automatic apply(input string tag, input logic r, input logic [31:0] va, input logic [31:0] vb,
                       input logic vc, input logic [31:0] es, input logic ec, input logic eo);
    rst = r; a = va; b = vb; cin = vc;
    @(posedge clk);
    #1;
    chk({tag, ".S"}, {32'h0, s}, {32'h0, es});
    chk({tag, ".C32"}, {63'h0, c32}, {63'h0, ec});
`ifdef ADDER32_OVF_EN
    chk({tag, ".OF"}, {63'h0, of}, {63'h0, eo});
`else
    if (eo === 1'bx) $display("note: %s has unknown overflow expectation", tag);
`endif
  endtask
  initial begin
    logic [32:0] ref33;
    logic        r, eo;
    apply("rst",      1'b1, 32'h12345678, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b0);
    apply("release",  1'b0, 32'h00000005, 32'h00000007, 1'b0, 32'h0000000C, 1'b0, 1'b0);
    apply("chain",    1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    apply("max",      1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    apply("ovf_pos",  1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    apply("ovf_neg",  1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
    apply("grp1",     1'b0, 32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0);
    apply("grp7",     1'b0, 32'h0FFFFFFF, 32'h00000001, 1'b0, 32'h10000000, 1'b0, 1'b0);
    apply("cin_half", 1'b0, 32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 1'b0, 1'b0);
    apply("mixed",    1'b0, 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0);
    apply("wrap",     1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    apply("rst_mid",  1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0);
    apply("alt",      1'b0, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 1'b0);
    for (int i = 0; i < 10000; i++) begin
      r = ($urandom_range(0, 49) == 0);
      a = $urandom;
      b = $urandom;
      cin = 1'($urandom % 2);
      ref33 = {1'b0, a} + {1'b0, b} + {32'h0, cin};
      eo = (a[31] == b[31]) && (ref33[31] != a[31]);
      apply("rand", r, a, b, cin, r ? 32'h0 : ref33[31:0], r ? 1'b0 : ref33[32], r ? 1'b0 : eo);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
